// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream of a
// pre-padded IMG_W x IMG_H image and emits every full 3x3 window, using two
// line buffers (previous row and the row before it) rather than a frame store.
// The output frame is (IMG_W-2) x (IMG_H-2) windows in raster order.
//
// Parameters:
//   PIX_W  pixel width in bits
//   IMG_W  padded line length in pixels (>= 3)
//   IMG_H  padded lines per frame (>= 3)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    in_pixel carries a pixel
//   in_ready    block can take a pixel this cycle
//   in_pixel    input pixel, raster order
//   out_valid   out_win holds a valid window
//   out_ready   downstream takes the window
//   out_win     window p1..p9, p1 in [PIX_W-1:0], p9 in the MSBs
//                 p1..p3 = row r-2, p4..p6 = row r-1, p7..p9 = row r,
//                 each group ordered columns c-2..c
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   out_sof     (WINGEN_FRAME_FLAGS_EN only) first window of a frame
//   out_eol     (WINGEN_FRAME_FLAGS_EN only) last window of an output line
//
// Build option:
//   WINGEN_FRAME_FLAGS_EN  adds the out_sof / out_eol flag outputs.
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 258,
    parameter int IMG_H = 258
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic               frame_done
`ifdef WINGEN_FRAME_FLAGS_EN
    ,
    output logic               out_sof,
    output logic               out_eol
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. valid never waits for ready; once raised it, and the data it
    // qualifies, hold until the transfer. Here in_ready = !out_valid ||
    // out_ready, so a pixel is only taken when the single output register is
    // free or being emptied on the same edge; nothing is ever dropped.

    logic acc;
    logic produce;
    logic last_col;
    logic last_row;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [PIX_W-1:0] lb0 [IMG_W];   // row r-1
    logic [PIX_W-1:0] lb1 [IMG_W];   // row r-2
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // win[i][j]: i = 0 top (r-2) .. 2 bottom (r); j = 0 oldest (c-2) .. 2 newest (c)
    logic [PIX_W-1:0] win [3][3];

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // Rows 0/1 and columns 0/1 never complete a window. Gating on both keeps
    // windows from straddling lines and keeps the previous frame's line-buffer
    // contents from ever reaching the output.
    assign produce = acc && (row >= ROW_TWO) && (col >= COL_TWO);

    // -------------------------------------------------------------------------
    // Raster position of the next pixel to be accepted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers: read combinationally at the current column, then each
    // entry ages by one row. Contents are deliberately not reset.
    // -------------------------------------------------------------------------
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= in_pixel;
        end
    end

    // -------------------------------------------------------------------------
    // Window shift register. It shifts on every accepted pixel, so while no
    // window is pending it keeps tracking the stream and the next produced
    // window is already assembled on the edge it becomes valid. While a window
    // is stalled, in_ready is low, so no shift can disturb it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (acc) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= in_pixel;
        end
    end

    always_comb begin
        out_win = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                out_win[(i*3 + j)*PIX_W +: PIX_W] = win[i][j];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output valid: a producing accept always wins, which covers the case of
    // the old window leaving and a new one arriving on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (produce) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc && last_row && last_col;
        end
    end

`ifdef WINGEN_FRAME_FLAGS_EN
    // Flags travel with the window: loaded with it, cleared when it leaves
    // without a replacement, so they are never high while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sof <= 1'b0;
            out_eol <= 1'b0;
        end else if (produce) begin
            out_sof <= (row == ROW_TWO) && (col == COL_TWO);
            out_eol <= last_col;
        end else if (out_valid && out_ready) begin
            out_sof <= 1'b0;
            out_eol <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//
// Self-checking bench for window_gen_3x3 on a 5x5 padded image (3x3 windows
// out). A reference image store and raster position inside the bench build
// each expected window when its last pixel is accepted; expected windows sit
// in exp_q until the DUT hands a window over.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int PIX_W = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int WW    = 9 * PIX_W;

    localparam logic [WW-1:0] WIN_FIRST   = 72'h0C_0B_0A_07_06_05_02_01_00;
    localparam logic [WW-1:0] WIN_LAST    = 72'h18_17_16_13_12_11_0E_0D_0C;
    localparam logic [WW-1:0] WIN_FIRST_B = 72'h70_6F_6E_6B_6A_69_66_65_64;

    // ---------------------------------------------------------------- clock/reset
    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [WW-1:0]    out_win;
    logic             frame_done;
`ifdef WINGEN_FRAME_FLAGS_EN
    logic             out_sof;
    logic             out_eol;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    window_gen_3x3 #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .frame_done(frame_done)
`ifdef WINGEN_FRAME_FLAGS_EN
        ,
        .out_sof   (out_sof),
        .out_eol   (out_eol)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    logic [WW-1:0]    exp_q[$];
    logic [1:0]       flag_q[$];     // {sof, eol}
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    int               tr;
    int               tc;

    int          n_cmp;
    int          n_err;
    int unsigned ready_pct;
    int          stall_left;
    logic [WW-1:0] hold_win;
    logic        last_acc;
    int          win_count;
    int          fd_count;
    logic [WW-1:0] first_win;
    logic [WW-1:0] last_win;

    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*PIX_W +: PIX_W] = img[r - 2 + k / 3][c - 2 + k % 3];
        end
        return w;
    endfunction

    // One clock of the bench. Called right after a falling edge with in_valid
    // and in_pixel already set; picks out_ready, scores any window handed
    // over, updates the reference model for any accepted pixel, then advances
    // to the next falling edge and checks the registered outputs.
    task automatic cycle();
        logic          acc;
        logic          pop;
        logic          prod;
        logic          fd_exp;
        logic [WW-1:0] exp_w;
        logic [1:0]    exp_f;
        if (stall_left > 0) out_ready = 1'b0;
        else                out_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        if (stall_left > 0) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_win !== hold_win) begin
                n_err++;
                $display("FAIL stall_hold: valid %b win %h want valid 1 win %h", out_valid, out_win, hold_win);
            end
            stall_left--;
        end
        acc    = in_valid && in_ready;
        pop    = out_valid && out_ready;
        prod   = 1'b0;
        fd_exp = 1'b0;
        if (pop) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_window: got %h want none", out_win);
            end else begin
                exp_w = exp_q.pop_front();
                exp_f = flag_q.pop_front();
                if (out_win !== exp_w) begin
                    n_err++;
                    $display("FAIL window: got %h want %h", out_win, exp_w);
                end
`ifdef WINGEN_FRAME_FLAGS_EN
                n_cmp++;
                if ({out_sof, out_eol} !== exp_f) begin
                    n_err++;
                    $display("FAIL flags: got sof/eol %b%b want %b", out_sof, out_eol, exp_f);
                end
`endif
                win_count++;
                if (win_count == 1) first_win = out_win;
                last_win = out_win;
            end
        end
        if (acc) begin
            img[tr][tc] = in_pixel;
            if (tr >= 2 && tc >= 2) begin
                exp_q.push_back(model_win(tr, tc));
                flag_q.push_back({(tr == 2 && tc == 2), (tc == IMG_W - 1)});
                prod = 1'b1;
            end
            fd_exp = (tr == IMG_H - 1) && (tc == IMG_W - 1);
            if (tc == IMG_W - 1) begin
                tc = 0;
                tr = (tr == IMG_H - 1) ? 0 : tr + 1;
            end else begin
                tc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (frame_done !== fd_exp) begin
            n_err++;
            $display("FAIL frame_done: got %b want %b", frame_done, fd_exp);
        end
        if (frame_done === 1'b1) fd_count++;
        if (prod) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL latency: out_valid got %b want 1", out_valid);
            end
        end
        last_acc = acc;
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic push_pixel(input logic [PIX_W-1:0] p);
        int n;
        in_valid = 1'b1;
        in_pixel = p;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 200);
        in_valid = 1'b0;
        if (!last_acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept want accept within 200 cycles");
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_pixel = PIX_W'($urandom_range(0, 255));
        cycle();
    endtask

    task automatic send_frame(input int base, input bit rand_pix, input bit gaps);
        int g;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                g = 0;
                while (gaps && $urandom_range(0, 1) == 0 && g < 8) begin
                    idle_cycle();
                    g++;
                end
                if (rand_pix) push_pixel(PIX_W'($urandom_range(0, 255)));
                else          push_pixel(PIX_W'(base + r * IMG_W + c));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_pct = 100;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
            idle_cycle();
            n++;
        end
        idle_cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d windows outstanding want 0", exp_q.size());
        end
    endtask

    task automatic clear_counts();
        win_count = 0;
        fd_count  = 0;
        first_win = '0;
        last_win  = '0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_win !== '0) begin n_err++; $display("FAIL reset_out_win: got %h want 0", out_win); end
        n_cmp++;
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
`ifdef WINGEN_FRAME_FLAGS_EN
        n_cmp++;
        if ({out_sof, out_eol} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", out_sof, out_eol); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_frame();
        clear_counts();
        ready_pct = 100;
        send_frame(0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (win_count != 9) begin n_err++; $display("FAIL basic_count: got %0d want 9", win_count); end
        n_cmp++;
        if (first_win !== WIN_FIRST) begin n_err++; $display("FAIL basic_first: got %h want %h", first_win, WIN_FIRST); end
        n_cmp++;
        if (last_win !== WIN_LAST) begin n_err++; $display("FAIL basic_last: got %h want %h", last_win, WIN_LAST); end
        n_cmp++;
        if (fd_count != 1) begin n_err++; $display("FAIL basic_frame_done_count: got %0d want 1", fd_count); end
    endtask

    task automatic test_second_frame();
        clear_counts();
        ready_pct = 100;
        send_frame(100, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (first_win !== WIN_FIRST_B) begin n_err++; $display("FAIL second_first: got %h want %h", first_win, WIN_FIRST_B); end
        n_cmp++;
        if (win_count != 9) begin n_err++; $display("FAIL second_count: got %0d want 9", win_count); end
    endtask

    task automatic test_backpressure();
        clear_counts();
        ready_pct = 100;
        for (int p = 0; p < 13; p++) push_pixel(PIX_W'(p));
        hold_win   = WIN_FIRST;
        stall_left = 4;
        for (int p = 13; p < IMG_W * IMG_H; p++) push_pixel(PIX_W'(p));
        drain();
        n_cmp++;
        if (stall_left != 0) begin n_err++; $display("FAIL bp_stall_cycles: got %0d left want 0", stall_left); end
        n_cmp++;
        if (win_count != 9 || last_win !== WIN_LAST) begin
            n_err++;
            $display("FAIL bp_sequence: got %0d windows last %h want 9 last %h", win_count, last_win, WIN_LAST);
        end
    endtask

    task automatic test_random();
        clear_counts();
        ready_pct = 50;
        send_frame(0, 1'b1, 1'b1);
        send_frame(0, 1'b1, 1'b1);
        drain();
        n_cmp++;
        if (win_count != 18) begin n_err++; $display("FAIL random_count: got %0d want 18", win_count); end
        n_cmp++;
        if (fd_count != 2) begin n_err++; $display("FAIL random_frame_done: got %0d want 2", fd_count); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        ready_pct = 100;
        for (int p = 0; p < 13; p++) push_pixel(PIX_W'(p));
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_win !== '0) begin n_err++; $display("FAIL midrst_out_win: got %h want 0", out_win); end
        exp_q.delete();
        flag_q.delete();
        tr = 0;
        tc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_counts();
        send_frame(0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (win_count != 9) begin n_err++; $display("FAIL midrst_count: got %0d want 9", win_count); end
        n_cmp++;
        if (first_win !== WIN_FIRST) begin n_err++; $display("FAIL midrst_first: got %h want %h", first_win, WIN_FIRST); end
    endtask

    // Back-to-back frames with gaps but a permanently ready sink.
    task automatic test_back_to_back();
        clear_counts();
        ready_pct = 100;
        send_frame(30, 1'b0, 1'b0);
        send_frame(0, 1'b1, 1'b1);
        drain();
        n_cmp++;
        if (win_count != 18 || fd_count != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d windows %0d done want 18 and 2", win_count, fd_count);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_pixel   = '0;
        out_ready  = 1'b1;
        n_cmp      = 0;
        n_err      = 0;
        ready_pct  = 100;
        stall_left = 0;
        hold_win   = '0;
        last_acc   = 1'b0;
        tr         = 0;
        tc         = 0;
        clear_counts();

        test_reset();
        test_basic_frame();
        test_second_frame();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
